uart_tx_arb: RTL and testbench



---
 rtl/uart_tx_arb.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter + 8N1 serializer sharing one UART TX among NREQ requesters; TX falls 1 cycle after accept.
// req_ready is offered only in IDLE, so one byte per 10*CLKS_PER_BIT+1 cycles; `UART_TX_ARB_LOCK_EN adds req_lock.
module uart_tx_arb #(
  parameter int NREQ         = 4,
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NREQ-1:0]         req_lock,
`endif
  output logic [NREQ-1:0]         req_ready,
  output logic                    TX,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);
  localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_grant;

  logic          w_any;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_win_next;
  logic          w_accept;
  logic          w_tc;
  logic          w_hold;
  logic [NREQ-1:0] w_ready;

`ifdef UART_TX_ARB_LOCK_EN
  logic r_locked;
  assign w_hold = req_lock[w_win];
`else
  assign w_hold = 1'b0;
`endif

  // Scan downward so the lowest offset from the pointer is the last (winning) match.
  always_comb begin
    logic [PW:0]   v_sum;
    logic [PW-1:0] v_idx;
    w_any = 1'b0;
    w_win = r_ptr;
    v_sum = '0;
    v_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      v_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (v_sum >= NREQ_W) begin
        v_sum = v_sum - NREQ_W;
      end
      v_idx = v_sum[PW-1:0];
      if (req_valid[v_idx]) begin
        w_any = 1'b1;
        w_win = v_idx;
      end
    end
`ifdef UART_TX_ARB_LOCK_EN
    if (r_locked) begin
      w_any = req_valid[r_ptr];
      w_win = r_ptr;
    end
`endif
  end

  assign w_win_next = (w_win == PTR_LAST) ? '0 : w_win + 1'b1;
  assign w_accept   = (r_state == S_IDLE) && w_any;
  assign w_tc       = (r_cnt == CNT_LAST);

  always_comb begin
    w_ready = '0;
    if (w_accept) begin
      w_ready[w_win] = 1'b1;
    end
  end

  // Gated by resetn so ready is low throughout reset even though the FSM sits in IDLE.
  assign req_ready = resetn ? w_ready : '0;
  assign TX        = r_tx;
  assign busy      = (r_state != S_IDLE);
  assign grant_id  = r_grant;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= req_data[{w_win, 3'b000} +: 8];
            r_grant <= w_win;
            r_ptr   <= w_hold ? w_win : w_win_next;
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tc) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tc) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tc) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_locked <= 1'b0;
    end else if (w_accept) begin
      r_locked <= w_hold;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb at NREQ=4, CLKS_PER_BIT=4: vector table of single grants plus multi-frame sequences.
module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int CPB  = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
`ifdef UART_TX_ARB_LOCK_EN
  logic [3:0]  req_lock = '0;
`endif
  logic [3:0]  req_ready;
  logic        TX;
  logic        busy;
  logic [1:0]  grant_id;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  uart_tx_arb #(.NREQ(NREQ), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .TX        (TX),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] valid;
    logic [7:0] base;
    logic [3:0] exp_ready;
    logic [1:0] exp_grant;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lanes(input logic [7:0] base);
    for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = base + 8'(i);
  endtask

  // Called just before the accept edge; returns #1 after the 40th frame cycle.
  task automatic take_frame(input string name, input logic [1:0] exp_grant,
                            input logic [7:0] exp_byte, output int t_acc);
    logic [63:0] w_tx, w_busy, w_exp;
    @(posedge clk); #1;
    t_acc = cyc;
    chk({name, " grant"}, grant_id, exp_grant);
    w_tx = '0; w_busy = '0; w_exp = '0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      w_tx[c]   = TX;
      w_busy[c] = busy;
      if (c >= 36) w_exp[c] = 1'b1;
      else if (c >= 4) w_exp[c] = exp_byte[(c-4)/4];
    end
    chk({name, " tx wave"}, w_tx, w_exp);
    chk({name, " busy wave"}, w_busy, 64'hFF_FFFF_FFFF);
  endtask

  task automatic to_idle_slot;
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, w, viol;
    vecs[0] = '{4'b0001, 8'h31, 4'b0001, 2'd0, 8'h31};
    vecs[1] = '{4'b1111, 8'h40, 4'b0010, 2'd1, 8'h41};
    vecs[2] = '{4'b0011, 8'h50, 4'b0001, 2'd0, 8'h50};
    vecs[3] = '{4'b0100, 8'hA0, 4'b0100, 2'd2, 8'hA2};
    vecs[4] = '{4'b1010, 8'h10, 4'b1000, 2'd3, 8'h13};
    vecs[5] = '{4'b1010, 8'h7C, 4'b0010, 2'd1, 8'h7D};
    vecs[6] = '{4'b0101, 8'hFC, 4'b0100, 2'd2, 8'hFE};
    vecs[7] = '{4'b0001, 8'h00, 4'b0001, 2'd0, 8'h00};
    vecs[8] = '{4'b1000, 8'hFC, 4'b1000, 2'd3, 8'hFF};

    // Reset state, with all requesters valid to prove ready stays low.
    req_valid = 4'hF;
    set_lanes(8'h31);
    #12;
    chk("reset tx", TX, 1);
    chk("reset busy", busy, 0);
    chk("reset ready", req_ready, 0);
    chk("reset grant", grant_id, 0);
    @(negedge clk);
    req_valid = '0;
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req_valid = vecs[i].valid;
      set_lanes(vecs[i].base);
      #1 chk($sformatf("vec%0d ready", i), req_ready, vecs[i].exp_ready);
      take_frame($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_byte, t0);
      req_valid = '0;
      @(posedge clk); #1;
      chk($sformatf("vec%0d idle tx", i), TX, 1);
      chk($sformatf("vec%0d idle busy", i), busy, 0);
    end

    // All contend, held until accepted: order 0..3 with 41-cycle spacing.
    @(negedge clk);
    req_valid = 4'hF;
    set_lanes(8'h31);
    t1 = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); @(negedge clk); end
      #1 chk($sformatf("contend%0d ready", k), req_ready, 64'(1) << k);
      take_frame($sformatf("contend%0d", k), 2'(k), 8'h31 + 8'(k), t0);
      if (k > 0) chk($sformatf("contend%0d spacing", k), t0 - t1, 41);
      t1 = t0;
      req_valid[k] = 1'b0;
    end

    // Pointer wrap: grant 2, then 1 and 3 valid -> 3 before 1.
    to_idle_slot();
    req_valid = 4'b0100;
    set_lanes(8'h61);
    #1 chk("wrap ready2", req_ready, 4'b0100);
    take_frame("wrap2", 2'd2, 8'h63, t0);
    req_valid = 4'b1010;
    to_idle_slot();
    #1 chk("wrap ready3", req_ready, 4'b1000);
    take_frame("wrap3", 2'd3, 8'h64, t0);
    req_valid = 4'b0010;
    to_idle_slot();
    #1 chk("wrap ready1", req_ready, 4'b0010);
    take_frame("wrap1", 2'd1, 8'h62, t0);
    req_valid = '0;

    // One-cycle valid pulse while busy is never accepted and leaves the pointer alone.
    to_idle_slot();
    req_valid = 4'b0001;
    set_lanes(8'h70);
    #1 chk("pulse base ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    req_valid = 4'b1000;
    #1 chk("pulse ready while busy", req_ready, 0);
    @(negedge clk);
    req_valid = '0;
    w = 0;
    while (busy && w < 100) begin @(negedge clk); w++; end
    chk("pulse busy drop", busy, 0);
    viol = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready != 0 || busy || !TX) viol++;
    end
    chk("pulse no frame", viol, 0);
    req_valid = 4'hF;
    set_lanes(8'h80);
    #1 chk("pulse ptr ready", req_ready, 4'b0010);
    take_frame("pulse ptr", 2'd1, 8'h81, t0);
    req_valid = '0;

    // Reset during DATA bit 3, then restart from pointer 0.
    to_idle_slot();
    req_valid = 4'b0010;
    set_lanes(8'h90);
    #1 chk("rst pre ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (17) @(posedge clk);
    #2;
    chk("rst pre tx", TX, 0);
    resetn = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("rst tx", TX, 1);
    chk("rst busy", busy, 0);
    chk("rst ready", req_ready, 0);
    chk("rst grant", grant_id, 0);
    @(negedge clk);
    resetn = 1'b1;
    set_lanes(8'h35);
    #1 chk("rst post ready", req_ready, 4'b0001);
    take_frame("rst post", 2'd0, 8'h35, t0);
    req_valid = '0;

`ifdef UART_TX_ARB_LOCK_EN
    // Locked message from req 1 stays contiguous while req 0 waits.
    to_idle_slot();
    req_data[7:0]  = 8'h30;
    req_data[15:8] = 8'h41;
    req_lock  = 4'b0010;
    req_valid = 4'b0011;
    #1 chk("lock ready A", req_ready, 4'b0010);
    take_frame("lock A", 2'd1, 8'h41, t0);
    req_data[15:8] = 8'h42;
    to_idle_slot();
    #1 chk("lock ready B", req_ready, 4'b0010);
    take_frame("lock B", 2'd1, 8'h42, t0);
    req_data[15:8] = 8'h43;
    req_lock = '0;
    to_idle_slot();
    #1 chk("lock ready C", req_ready, 4'b0010);
    take_frame("lock C", 2'd1, 8'h43, t0);
    req_valid = 4'b0001;
    to_idle_slot();
    #1 chk("lock ready 0", req_ready, 4'b0001);
    take_frame("lock 0", 2'd0, 8'h30, t0);
    req_valid = '0;
`endif

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
